// File: rtl/alu_seq.sv
// Sequential ALU: captures operands on start, runs single-cycle logic/arithmetic ops
// and multi-cycle shift-left and unsigned multiply, then holds result and flags.
module alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             v,
    output logic             n,
    output logic             z,
    output logic             p
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 sc_q, sc_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic                 c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d, p_q, p_d;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       step_sum;
    logic [WIDTH-1:0]     res_y;
    logic                 res_c;
    logic                 res_v;

    // Final result from the captured operands and the iteration registers.
    always_comb begin
        sum   = '0;
        res_y = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (op_q)
            3'd0: begin
                sum   = {1'b0, a_q} + {1'b0, b_q};
                res_y = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_y[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'd1: begin
                sum   = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
                res_y = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_y[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'd2: res_y = a_q & b_q;
            3'd3: res_y = a_q | b_q;
            3'd4: res_y = a_q ^ b_q;
            3'd5: res_y = ~a_q;
            3'd6: begin
                res_y = a_q;
                res_c = sc_q;
            end
            3'd7: begin
                res_y = prod_q[WIDTH-1:0];
                res_c = |prod_q[2*WIDTH-1:WIDTH];
            end
        endcase
    end

    // Shift-add step: high half accumulates, low half holds the remaining multiplier bits.
    assign step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        sc_d    = sc_q;
        done_d  = 1'b0;
        y_d     = y_q;
        c_d     = c_q;
        v_d     = v_q;
        n_d     = n_q;
        z_d     = z_q;
        p_d     = p_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = aluop;
                    sc_d    = 1'b0;
                    prod_d  = {{WIDTH{1'b0}}, b};
                    state_d = StRun;
                    if (aluop == 3'd6) begin
                        cnt_d = CW'(b[SHW-1:0]);
                    end else if (aluop == 3'd7) begin
                        cnt_d = CW'(WIDTH);
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            StRun: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                    if (op_q == 3'd6) begin
                        sc_d = a_q[WIDTH-1];
                        a_d  = {a_q[WIDTH-2:0], 1'b0};
                    end else if (op_q == 3'd7) begin
                        prod_d = {step_sum, prod_q[WIDTH-1:1]};
                    end
                end else begin
                    y_d     = res_y;
                    c_d     = res_c;
                    v_d     = res_v;
                    n_d     = res_y[WIDTH-1];
                    z_d     = (res_y == '0);
                    p_d     = ^res_y;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            sc_q    <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            p_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            sc_q    <= sc_d;
            done_q  <= done_d;
            y_q     <= y_d;
            c_q     <= c_d;
            v_q     <= v_d;
            n_q     <= n_d;
            z_q     <= z_d;
            p_q     <= p_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign y    = y_q;
    assign c    = c_q;
    assign v    = v_q;
    assign n    = n_q;
    assign z    = z_q;
    assign p    = p_q;

endmodule
